data_memory_param: RTL and testbench
====================================

# data_memory_param

Parametrised successor to the 8-bit x 32 data memory, sitting between the datapath ALU/address logic and the register file write-back.
- Width, depth and address width are generics.
- Reads are registered with a valid strobe.
- Out-of-range accesses are flagged.
- The fixed-pattern clear is replaced by a sequential init engine that writes the pattern one entry per cycle while reporting busy.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (>= 2)
- DEPTH, 32, number of words; even, <= 2^ADDR_W
- ADDR_W, 8, address port width

Ports:
- clock  in  1  single clock, all logic on rising edge
- clear  in  1  synchronous active-high reset; starts init sequence
- signal_memread  in  1  read request, sampled at clock edge
- signal_memwrite  in  1  write request, sampled at clock edge
- address  in  ADDR_W  word address for read and write
- data_to_write  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- data_valid  out  1  data_out holds the result of a read accepted last cycle
- busy  out  1  init sequence in progress; requests ignored
- addr_error  out  1  one-cycle pulse: an accepted request had address >= DEPTH

## Operation
- State machine with two states: INIT and READY.
- clear=1 at an edge:
  - state<=INIT, init pointer<=0
  - data_out<=0, data_valid<=0, addr_error<=0, busy<=1
  - memory contents not yet rewritten
- INIT with clear=0:
  - Each cycle writes mem[ptr]<=init(ptr), then ptr<=ptr+1.
  - After writing ptr==DEPTH-1: state<=READY, busy<=0.
- init(i) pattern:
  - For i < DEPTH/2: init(i) = i.
  - For i >= DEPTH/2: init(i) = -(i-DEPTH/2) in two's complement.
  - Both cases are truncated to DATA_W bits.
  - For the default 32x8 this gives 0..15, then 0, FF, FE .. F1.
- READY, request acceptance:
  - signal_memread and signal_memwrite are accepted independently; both may be set in the same cycle.
- Write:
  - If address < DEPTH: mem[address]<=data_to_write.
  - Else: memory unchanged, addr_error<=1.
- Read:
  - data_valid<=1.
  - data_out<=mem[address] if address < DEPTH.
  - Else data_out<=0 and addr_error<=1.
- Read and write to the same address in one cycle: read-first; data_out returns the pre-write value.
- Read not requested: data_valid<=0, data_out holds its last value.
- Requests while busy: silently dropped; data_valid=0, addr_error=0, memory untouched.
- clear mid-INIT: pointer restarts at 0; the full DEPTH-cycle sequence reruns.
- clear mid-READY: the pending read result is discarded (data_valid<=0).

## Timing
- Reset values: data_out=0, data_valid=0, addr_error=0, busy=1.
- Init duration:
  - busy stays high for exactly DEPTH cycles after the first edge with clear=0.
  - The first request is accepted at edge DEPTH+1 after clear falls.
- Read latency: 1 cycle. Request at edge N gives data_out/data_valid valid after edge N, usable at edge N+1.
- Back-to-back reads: one per cycle, no bubbles.
- Write latency: visible to a read issued at the next edge.
- addr_error: asserted for the single cycle following the offending request.

## Structure
- Shared package data_memory_pkg holds:
  - state enum (ST_INIT, ST_READY)
  - function init_value(i, DEPTH, DATA_W)
  - elaboration-time checks: DEPTH even, DEPTH <= 2^ADDR_W
- Sub-module memory_init_sequencer:
  - owns the state register, pointer and busy
  - outputs init write-enable, address and data
  - the top level multiplexes init writes with user writes (init has priority; users are blocked while busy)

## Test plan
- Clear held 3 cycles, then released. busy stays 1 for 32 cycles then drops. Reads of addr 0, 15, 16, 17, 31 return 00, 0F, 00, FF, F1.
- READY, write addr 5 <= A5, read addr 5 next cycle. data_out=A5, data_valid=1 exactly one cycle after the read request.
- Simultaneous read+write to addr 3, data 77. data_out=03 (old value). A following read returns 77.
- Write addr 40 <= 55, then read addr 40. addr_error pulses each time, data_out=00, entries 0..31 unchanged.
- Assert clear at init pointer 10, release. busy lasts a full 32 further cycles. Requests during busy produce no data_valid and no writes.
- DATA_W=16, DEPTH=64: after init, addr 33 reads FFFF and addr 63 reads FFE1.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the parametrised data memory: FSM states,
// the init fill pattern and elaboration-time parameter checks.
package data_memory_pkg;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_READY
  } state_t;

  // Entry i of the init pattern, masked to data_w bits (data_w <= 64).
  function automatic logic [63:0] init_value(input int unsigned i,
                                             input int unsigned depth,
                                             input int unsigned data_w);
    logic [63:0] v;
    logic [63:0] mask;
    if (i < depth / 2) v = 64'(i);
    else               v = -64'(i - depth / 2);
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return v & mask;
  endfunction

  function automatic bit depth_fits(input int unsigned depth,
                                    input int unsigned addr_w);
    return (addr_w >= 32) || (64'(depth) <= (64'd1 << addr_w));
  endfunction

endpackage

// File: rtl/memory_init_sequencer.sv
// Owns the INIT/READY state, the fill pointer and busy; emits one pattern
// write per cycle while initialising.
module memory_init_sequencer
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              clear,
  output logic              busy,
  output logic              init_we,
  output logic [PTR_W-1:0]  init_addr,
  output logic [DATA_W-1:0] init_data
);

  state_t           state;
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_INIT;
      ptr   <= '0;
      busy  <= 1'b1;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == PTR_W'(DEPTH - 1)) begin
        state <= ST_READY;
        busy  <= 1'b0;
      end
    end
  end

  // No pattern writes on a clear edge: the clear itself leaves memory as is.
  always_comb begin
    init_we   = (state == ST_INIT) && !clear;
    init_addr = ptr;
    init_data = DATA_W'(init_value(32'(ptr), DEPTH, DATA_W));
  end

endmodule

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with registered reads, a valid
// strobe, out-of-range flagging and a sequential pattern-init engine.
module data_memory_param
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              signal_memread,
  input  logic              signal_memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_to_write,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              addr_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (DEPTH % 2 != 0 || DEPTH < 2) begin : g_bad_depth
    $error("data_memory_param: DEPTH must be even and >= 2");
  end
  if (!depth_fits(DEPTH, ADDR_W)) begin : g_bad_addr
    $error("data_memory_param: DEPTH exceeds 2**ADDR_W");
  end
  if (DATA_W < 2 || DATA_W > 64) begin : g_bad_width
    $error("data_memory_param: DATA_W must be in 2..64");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [PTR_W-1:0]  init_addr;
  logic [DATA_W-1:0] init_data;

  memory_init_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_seq (
    .clock     (clock),
    .clear     (clear),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  logic             accept;
  logic             in_range;
  logic [PTR_W-1:0] idx;

  // Extra compare bit so DEPTH == 2**ADDR_W does not wrap to zero.
  always_comb begin
    accept   = !busy && !clear;
    in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
    idx      = address[PTR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (init_we)
      mem[init_addr] <= init_data;
    else if (accept && signal_memwrite && in_range)
      mem[idx] <= data_to_write;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      data_valid <= accept && signal_memread;
      addr_error <= accept && (signal_memread || signal_memwrite) && !in_range;
      if (accept && signal_memread)
        data_out <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Directed, table-driven bench for data_memory_param (32x8 and 64x16).
module tb_data_memory_param;

  logic       clk = 1'b0;
  logic       clear, rd, wr;
  logic [7:0] addr, wd, dout;
  logic       valid, busy, err;

  logic        clear2, rd2;
  logic [7:0]  addr2;
  logic [15:0] dout2;
  logic        valid2, busy2, err2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_memory_param #(.DATA_W(8), .DEPTH(32), .ADDR_W(8)) dut (
    .clock(clk), .clear(clear), .signal_memread(rd), .signal_memwrite(wr),
    .address(addr), .data_to_write(wd), .data_out(dout), .data_valid(valid),
    .busy(busy), .addr_error(err)
  );

  data_memory_param #(.DATA_W(16), .DEPTH(64), .ADDR_W(8)) dut2 (
    .clock(clk), .clear(clear2), .signal_memread(rd2), .signal_memwrite(1'b0),
    .address(addr2), .data_to_write(16'h0000), .data_out(dout2), .data_valid(valid2),
    .busy(busy2), .addr_error(err2)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] eq;
    logic       ee;
    string      nm;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic w, logic [7:0] a, logic [7:0] d,
                              logic ev, logic [7:0] eq, logic ee, string nm);
    vec_t v;
    v.rd = r; v.wr = w; v.a = a; v.d = d; v.ev = ev; v.eq = eq; v.ee = ee; v.nm = nm;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step(logic r, logic w, logic [7:0] a, logic [7:0] d);
    rd = r; wr = w; addr = a; wd = d;
    @(posedge clk); #1;
  endtask

  logic [7:0] model [32];
  bit seen_valid, seen_err;

  initial begin
    clear = 1'b1; clear2 = 1'b1;
    rd = 0; wr = 0; addr = 0; wd = 0; rd2 = 0; addr2 = 0;
    for (int i = 0; i < 32; i++) model[i] = (i < 16) ? 8'(i) : 8'(256 - (i - 16));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout, 0);
    chk("reset_valid", valid, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 1);
    chk("reset_busy2", busy2, 1);

    // First init: read requests while busy must never produce valid.
    clear = 0; clear2 = 0;
    seen_valid = 0;
    for (int k = 1; k <= 64; k++) begin
      rd = (k <= 31); addr = 8'd0;
      @(posedge clk); #1;
      if (k <= 32 && valid) seen_valid = 1;
      if (k == 31) chk("busy_at_31", busy, 1);
      if (k == 32) chk("busy_at_32", busy, 0);
      if (k == 63) chk("busy2_at_63", busy2, 1);
      if (k == 64) chk("busy2_at_64", busy2, 0);
    end
    chk("no_valid_while_busy", seen_valid, 0);

    vt.push_back(mk(1, 0, 8'd0,   8'h00, 1, 8'h00, 0, "rd0"));
    vt.push_back(mk(1, 0, 8'd15,  8'h00, 1, 8'h0F, 0, "rd15"));
    vt.push_back(mk(1, 0, 8'd16,  8'h00, 1, 8'h00, 0, "rd16"));
    vt.push_back(mk(1, 0, 8'd17,  8'h00, 1, 8'hFF, 0, "rd17"));
    vt.push_back(mk(1, 0, 8'd31,  8'h00, 1, 8'hF1, 0, "rd31"));
    vt.push_back(mk(0, 1, 8'd5,   8'hA5, 0, 8'hF1, 0, "wr5"));
    vt.push_back(mk(1, 0, 8'd5,   8'h00, 1, 8'hA5, 0, "rd5"));
    vt.push_back(mk(0, 0, 8'd0,   8'h00, 0, 8'hA5, 0, "idle_hold"));
    vt.push_back(mk(1, 1, 8'd3,   8'h77, 1, 8'h03, 0, "rdwr3_old"));
    vt.push_back(mk(1, 0, 8'd3,   8'h00, 1, 8'h77, 0, "rd3_new"));
    vt.push_back(mk(0, 1, 8'd40,  8'h55, 0, 8'h77, 1, "wr40_err"));
    vt.push_back(mk(1, 0, 8'd40,  8'h00, 1, 8'h00, 1, "rd40_err"));
    vt.push_back(mk(0, 0, 8'd0,   8'h00, 0, 8'h00, 0, "err_clears"));
    vt.push_back(mk(0, 1, 8'd31,  8'h3C, 0, 8'h00, 0, "wr31"));
    vt.push_back(mk(1, 0, 8'd31,  8'h00, 1, 8'h3C, 0, "rd31_new"));
    vt.push_back(mk(1, 0, 8'd32,  8'h00, 1, 8'h00, 1, "rd32_err"));
    vt.push_back(mk(1, 1, 8'd255, 8'h11, 1, 8'h00, 1, "rdwr255_err"));
    model[5] = 8'hA5; model[3] = 8'h77; model[31] = 8'h3C;

    foreach (vt[i]) begin
      step(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d);
      chk({vt[i].nm, "_valid"}, valid, vt[i].ev);
      chk({vt[i].nm, "_data"}, dout, vt[i].eq);
      chk({vt[i].nm, "_err"}, err, vt[i].ee);
    end

    // Back-to-back sweep: every entry matches the model, out-of-range writes left no trace.
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 8'(i), 8'h00);
      chk($sformatf("sweep%0d", i), {valid, dout}, {1'b1, model[i]});
    end

    // Clear while READY with a read result pending.
    step(1, 0, 8'd1, 8'h00);
    chk("pending_valid", valid, 1);
    clear = 1;
    step(0, 0, 8'd0, 8'h00);
    chk("clr_ready_valid", valid, 0);
    chk("clr_ready_dout", dout, 0);
    chk("clr_ready_busy", busy, 1);

    // Partial init up to pointer 10, then clear restarts the full sequence.
    clear = 0;
    repeat (10) step(0, 0, 8'd0, 8'h00);
    chk("mid_init_busy", busy, 1);
    clear = 1;
    step(0, 0, 8'd0, 8'h00);
    clear = 0;
    seen_valid = 0; seen_err = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k >= 6) step(1, 1, 8'd2, 8'hAA);
      else        step(0, 0, 8'd0, 8'h00);
      if (valid) seen_valid = 1;
      if (err) seen_err = 1;
      if (k == 31) chk("rerun_busy_31", busy, 1);
      if (k == 32) chk("rerun_busy_32", busy, 0);
    end
    chk("rerun_no_valid", seen_valid, 0);
    chk("rerun_no_err", seen_err, 0);
    step(1, 0, 8'd2, 8'h00);
    chk("rd2_after_rerun", dout, 8'h02);
    step(1, 0, 8'd5, 8'h00);
    chk("rd5_restored", dout, 8'h05);
    step(0, 0, 8'd0, 8'h00);

    // 64x16 instance pattern.
    rd2 = 1;
    addr2 = 8'd33; @(posedge clk); #1; chk("w16_rd33", {valid2, dout2}, {1'b1, 16'hFFFF});
    addr2 = 8'd63; @(posedge clk); #1; chk("w16_rd63", {valid2, dout2}, {1'b1, 16'hFFE1});
    addr2 = 8'd31; @(posedge clk); #1; chk("w16_rd31", dout2, 16'h001F);
    addr2 = 8'd32; @(posedge clk); #1; chk("w16_rd32", dout2, 16'h0000);
    addr2 = 8'd64; @(posedge clk); #1; chk("w16_rd64_err", {err2, dout2}, {1'b1, 16'h0000});
    rd2 = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
